mem_arbiter: RTL and testbench

//   Shares the single pipelined main memory between I-cache fill, D-cache fill and
//   D-cache write-through requests. Grants one requester at a time and issues its

---
 rtl/mem_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single pipelined main memory between I-cache fill,
// D-cache fill and D-cache write-through. One requester is granted at a time;
// a fill issues WORDS pipelined word reads, a write issues one word write.
// Read data flows straight from memory to both caches; only control is routed here.
// Optional build macro ARB_RR_EN: fills alternate between D and I when both are
// pending (write-through keeps top priority). Default build is fixed priority
// dc_wr_req > dc_miss > ic_miss.
module mem_arbiter #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned WORDS  = 8
) (
   input  logic                       clk,
   input  logic                       rst,

   input  logic                       ic_miss,
   input  logic [ADDR_W-1:0]          ic_addr,
   output logic                       ic_busy,
   output logic                       ic_data_valid,
   output logic [$clog2(WORDS)-1:0]   ic_offset,
   output logic                       ic_fill_done,

   input  logic                       dc_miss,
   input  logic [ADDR_W-1:0]          dc_addr,
   output logic                       dc_busy,
   output logic                       dc_data_valid,
   output logic [$clog2(WORDS)-1:0]   dc_offset,
   output logic                       dc_fill_done,

   input  logic                       dc_wr_req,
   input  logic [ADDR_W-1:0]          dc_wr_addr,
   input  logic [DATA_W-1:0]          dc_wr_data,
   output logic                       dc_wr_ack,

   output logic                       mem_en,
   output logic                       mem_wr,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   input  logic                       mem_data_valid
);

   localparam int unsigned OFF_W  = $clog2(WORDS);
   localparam int unsigned LSB_W  = OFF_W + 1;          // word offset plus byte bit
   localparam int unsigned BASE_W = ADDR_W - LSB_W;
   localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_IFILL  = 2'd1,
      S_DFILL  = 2'd2,
      S_DWRITE = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [OFF_W-1:0]    req_cnt_q, req_cnt_d;
   logic [OFF_W-1:0]    rcv_cnt_q, rcv_cnt_d;
   logic [BASE_W-1:0]   base_q, base_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                wr_ack_q, wr_ack_d;
`ifdef ARB_RR_EN
   logic                last_fill_q, last_fill_d;   // 1: D-cache fill served last
`endif

   logic                grant_dc, grant_ic;
   logic [ADDR_W-1:0]   fill_addr;
   logic [OFF_W-1:0]    req_nxt;
   logic                fill_act, rx_valid, rx_last;

   // Byte/word offset bits of the miss addresses are dropped: fills are block aligned
   logic                unused_addr_lsbs;
   assign unused_addr_lsbs = ^{ic_addr[LSB_W-1:0], dc_addr[LSB_W-1:0]};

   assign fill_act = (state_q == S_IFILL) || (state_q == S_DFILL);
   assign rx_valid = fill_act & mem_data_valid;
   assign rx_last  = rx_valid & (rcv_cnt_q == LAST_IDX);

   // Fill arbitration between the two caches (write-through is handled ahead of this)
   always_comb begin
      grant_dc = 1'b0;
      grant_ic = 1'b0;
`ifdef ARB_RR_EN
      grant_dc = dc_miss & (~ic_miss | ~last_fill_q);
`else
      grant_dc = dc_miss;
`endif
      grant_ic  = ic_miss & ~grant_dc;
      fill_addr = grant_dc ? dc_addr : ic_addr;
   end

   // Next state, counters and registered memory command
   always_comb begin
      state_d     = state_q;
      req_cnt_d   = req_cnt_q;
      rcv_cnt_d   = rcv_cnt_q;
      base_d      = base_q;
      mem_en_d    = 1'b0;
      mem_wr_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      wr_ack_d    = 1'b0;
`ifdef ARB_RR_EN
      last_fill_d = last_fill_q;
`endif
      req_nxt     = req_cnt_q + OFF_W'(1);

      case (state_q)
         S_IDLE: begin
            if (dc_wr_req) begin
               state_d     = S_DWRITE;
               mem_en_d    = 1'b1;
               mem_wr_d    = 1'b1;
               mem_addr_d  = dc_wr_addr;
               mem_wdata_d = dc_wr_data;
               wr_ack_d    = 1'b1;
            end else if (grant_dc | grant_ic) begin
               state_d    = grant_dc ? S_DFILL : S_IFILL;
               base_d     = fill_addr[ADDR_W-1:LSB_W];
               req_cnt_d  = '0;
               rcv_cnt_d  = '0;
               mem_en_d   = 1'b1;
               mem_addr_d = {fill_addr[ADDR_W-1:LSB_W], LSB_W'(0)};
`ifdef ARB_RR_EN
               last_fill_d = grant_dc;
`endif
            end
         end

         S_IFILL, S_DFILL: begin
            // Keep issuing until the last word has gone out, then hold at LAST_IDX
            if (mem_en_q && (req_cnt_q != LAST_IDX)) begin
               req_cnt_d  = req_nxt;
               mem_en_d   = 1'b1;
               mem_addr_d = {base_q, req_nxt, 1'b0};
            end
            if (rx_valid) begin
               rcv_cnt_d = rcv_cnt_q + OFF_W'(1);
            end
            if (rx_last) begin
               state_d = S_IDLE;
            end
         end

         S_DWRITE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         req_cnt_q   <= '0;
         rcv_cnt_q   <= '0;
         base_q      <= '0;
         mem_en_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         wr_ack_q    <= 1'b0;
`ifdef ARB_RR_EN
         last_fill_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         req_cnt_q   <= req_cnt_d;
         rcv_cnt_q   <= rcv_cnt_d;
         base_q      <= base_d;
         mem_en_q    <= mem_en_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         wr_ack_q    <= wr_ack_d;
`ifdef ARB_RR_EN
         last_fill_q <= last_fill_d;
`endif
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign dc_wr_ack = wr_ack_q;

   // Returning read data is steered to whichever cache owns the current fill
   assign ic_busy       = ic_miss | (state_q == S_IFILL);
   assign ic_data_valid = mem_data_valid & (state_q == S_IFILL);
   assign ic_offset     = (state_q == S_IFILL) ? rcv_cnt_q : '0;
   assign ic_fill_done  = ic_data_valid & (rcv_cnt_q == LAST_IDX);

   assign dc_busy       = dc_miss | (state_q == S_DFILL);
   assign dc_data_valid = mem_data_valid & (state_q == S_DFILL);
   assign dc_offset     = (state_q == S_DFILL) ? rcv_cnt_q : '0;
   assign dc_fill_done  = dc_data_valid & (rcv_cnt_q == LAST_IDX);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter, one record per clock cycle.
module tb_mem_arbiter;

   typedef struct packed {
      logic        rst;
      logic        ic_miss;
      logic [15:0] ic_addr;
      logic        dc_miss;
      logic [15:0] dc_addr;
      logic        dc_wr_req;
      logic [15:0] dc_wr_addr;
      logic [15:0] dc_wr_data;
      logic        mem_dv;
   } in_t;

   typedef struct packed {
      logic        ic_busy;
      logic        ic_dv;
      logic [2:0]  ic_off;
      logic        ic_done;
      logic        dc_busy;
      logic        dc_dv;
      logic [2:0]  dc_off;
      logic        dc_done;
      logic        ack;
      logic        mem_en;
      logic        mem_wr;
      logic [15:0] mem_addr;
      logic [15:0] mem_wdata;
   } out_t;

   typedef struct {
      in_t  vi;
      out_t ve;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        ic_miss, dc_miss, dc_wr_req, mem_data_valid;
   logic [15:0] ic_addr, dc_addr, dc_wr_addr, dc_wr_data;
   logic        ic_busy, ic_data_valid, ic_fill_done;
   logic        dc_busy, dc_data_valid, dc_fill_done, dc_wr_ack;
   logic [2:0]  ic_offset, dc_offset;
   logic        mem_en, mem_wr;
   logic [15:0] mem_addr, mem_wdata;

   int n_vec = 0;
   int n_err = 0;

   vec_t tbl[32];
   int   n_tbl;
   in_t  vi;
   out_t ve;
   int   tt;

   mem_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .ic_miss       (ic_miss),
      .ic_addr       (ic_addr),
      .ic_busy       (ic_busy),
      .ic_data_valid (ic_data_valid),
      .ic_offset     (ic_offset),
      .ic_fill_done  (ic_fill_done),
      .dc_miss       (dc_miss),
      .dc_addr       (dc_addr),
      .dc_busy       (dc_busy),
      .dc_data_valid (dc_data_valid),
      .dc_offset     (dc_offset),
      .dc_fill_done  (dc_fill_done),
      .dc_wr_req     (dc_wr_req),
      .dc_wr_addr    (dc_wr_addr),
      .dc_wr_data    (dc_wr_data),
      .dc_wr_ack     (dc_wr_ack),
      .mem_en        (mem_en),
      .mem_wr        (mem_wr),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_data_valid(mem_data_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic string fmt(input out_t o);
      return $sformatf("ic{b%0d v%0d o%0d d%0d} dc{b%0d v%0d o%0d d%0d} ack%0d mem{e%0d w%0d a%h d%h}",
                       o.ic_busy, o.ic_dv, o.ic_off, o.ic_done,
                       o.dc_busy, o.dc_dv, o.dc_off, o.dc_done,
                       o.ack, o.mem_en, o.mem_wr, o.mem_addr, o.mem_wdata);
   endfunction

   // One clock cycle: drive inputs, compare all outputs mid-cycle, advance past the edge
   task automatic apply(input in_t i, input out_t e, input string nm);
      out_t got;
      rst            = i.rst;
      ic_miss        = i.ic_miss;
      ic_addr        = i.ic_addr;
      dc_miss        = i.dc_miss;
      dc_addr        = i.dc_addr;
      dc_wr_req      = i.dc_wr_req;
      dc_wr_addr     = i.dc_wr_addr;
      dc_wr_data     = i.dc_wr_data;
      mem_data_valid = i.mem_dv;
      @(negedge clk);
      got.ic_busy   = ic_busy;
      got.ic_dv     = ic_data_valid;
      got.ic_off    = ic_offset;
      got.ic_done   = ic_fill_done;
      got.dc_busy   = dc_busy;
      got.dc_dv     = dc_data_valid;
      got.dc_off    = dc_offset;
      got.dc_done   = dc_fill_done;
      got.ack       = dc_wr_ack;
      got.mem_en    = mem_en;
      got.mem_wr    = mem_wr;
      got.mem_addr  = mem_addr;
      got.mem_wdata = mem_wdata;
      n_vec++;
      if (got !== e) begin
         n_err++;
         $display("FAIL %s: got %s want %s", nm, fmt(got), fmt(e));
      end
      @(posedge clk);
      #1;
   endtask

   // Grant cycle plus a complete fill. The first word returns two cycles after its
   // issue; later words follow after a gap taken from gaps[2*j +: 2].
   task automatic do_fill(input logic is_d, input logic [15:0] a0, input logic [15:0] a_mid,
                          input logic oth, input logic [15:0] oth_a,
                          input logic [15:0] gaps, input string nm);
      in_t  i;
      out_t e;
      logic [15:0] base;
      int j, nret, t;
      base = {a0[15:4], 4'h0};
      i = '0;
      i.ic_miss = is_d ? oth : 1'b1;
      i.dc_miss = is_d ? 1'b1 : oth;
      i.ic_addr = is_d ? oth_a : a0;
      i.dc_addr = is_d ? a0 : oth_a;
      e = '0;
      e.ic_busy = i.ic_miss;
      e.dc_busy = i.dc_miss;
      apply(i, e, {nm, " grant"});
      j = 0;
      nret = 2;
      t = 0;
      while (j < 8) begin
         if (t == 1) begin
            if (is_d) i.dc_addr = a_mid;
            else      i.ic_addr = a_mid;
         end
         i.mem_dv   = (t == nret);
         e          = '0;
         e.ic_busy  = i.ic_miss;
         e.dc_busy  = i.dc_miss;
         e.mem_en   = (t < 8);
         e.mem_addr = (t < 8) ? base + 16'(2 * t) : 16'h0000;
         if (is_d) begin
            e.dc_dv   = i.mem_dv;
            e.dc_off  = 3'(j);
            e.dc_done = i.mem_dv && (j == 7);
         end else begin
            e.ic_dv   = i.mem_dv;
            e.ic_off  = 3'(j);
            e.ic_done = i.mem_dv && (j == 7);
         end
         apply(i, e, $sformatf("%s t%0d", nm, t));
         if (i.mem_dv) begin
            j++;
            if (j < 8) nret = t + 1 + int'(gaps[2*j +: 2]);
         end
         t++;
      end
   endtask

   initial begin
      rst = 1'b1;
      ic_miss = 1'b0; dc_miss = 1'b0; dc_wr_req = 1'b0; mem_data_valid = 1'b0;
      ic_addr = '0; dc_addr = '0; dc_wr_addr = '0; dc_wr_data = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      vi = '0; vi.rst = 1'b1; ve = '0;
      apply(vi, ve, "reset");

      // ---- table: I fill of 1234, stray data in IDLE, single write ----
      n_tbl = 0;
      for (int k = 0; k < 12; k++) begin
         vi = '0; ve = '0;
         vi.ic_miss = (k < 11);
         vi.ic_addr = 16'h1234;
         ve.ic_busy = (k < 11);
         if (k >= 1 && k <= 10) begin
            tt = k - 1;
            ve.mem_en   = (tt < 8);
            ve.mem_addr = (tt < 8) ? 16'h1230 + 16'(2 * tt) : 16'h0000;
            vi.mem_dv   = (tt >= 2);
            ve.ic_dv    = vi.mem_dv;
            ve.ic_off   = (tt >= 2) ? 3'(tt - 2) : 3'd0;
            ve.ic_done  = (tt == 9);
         end
         tbl[n_tbl].vi = vi; tbl[n_tbl].ve = ve; n_tbl++;
      end
      for (int k = 0; k < 2; k++) begin
         vi = '0; vi.mem_dv = 1'b1; ve = '0;
         tbl[n_tbl].vi = vi; tbl[n_tbl].ve = ve; n_tbl++;
      end
      vi = '0; vi.dc_wr_req = 1'b1; vi.dc_wr_addr = 16'hA5A4; vi.dc_wr_data = 16'hBEEF;
      ve = '0;
      tbl[n_tbl].vi = vi; tbl[n_tbl].ve = ve; n_tbl++;
      vi.mem_dv = 1'b1;
      ve.ack = 1'b1; ve.mem_en = 1'b1; ve.mem_wr = 1'b1;
      ve.mem_addr = 16'hA5A4; ve.mem_wdata = 16'hBEEF;
      tbl[n_tbl].vi = vi; tbl[n_tbl].ve = ve; n_tbl++;
      vi = '0; ve = '0;
      tbl[n_tbl].vi = vi; tbl[n_tbl].ve = ve; n_tbl++;

      for (int i = 0; i < n_tbl; i++) apply(tbl[i].vi, tbl[i].ve, $sformatf("tbl%0d", i));

      // ---- all three requests together: write, then D fill, then I fill ----
      vi = '0;
      vi.dc_wr_req = 1'b1; vi.dc_wr_addr = 16'h0100; vi.dc_wr_data = 16'h1111;
      vi.dc_miss = 1'b1; vi.dc_addr = 16'h2000;
      vi.ic_miss = 1'b1; vi.ic_addr = 16'h3000;
      ve = '0; ve.ic_busy = 1'b1; ve.dc_busy = 1'b1;
      apply(vi, ve, "t2 arb");
      ve.ack = 1'b1; ve.mem_en = 1'b1; ve.mem_wr = 1'b1;
      ve.mem_addr = 16'h0100; ve.mem_wdata = 16'h1111;
      apply(vi, ve, "t2 write");
      do_fill(1'b1, 16'h2000, 16'h2000, 1'b1, 16'h3000, 16'h0000, "t2 dfill");
      do_fill(1'b0, 16'h3000, 16'h3000, 1'b0, 16'h0000, 16'h0000, "t2 ifill");

      // Fresh pair, then D re-misses at once while I is still waiting
      do_fill(1'b1, 16'h2010, 16'h2010, 1'b1, 16'h3010, 16'h0000, "t2 pair1 d");
`ifdef ARB_RR_EN
      do_fill(1'b0, 16'h3010, 16'h3010, 1'b1, 16'h2020, 16'h0000, "t2 pair2 i");
      do_fill(1'b1, 16'h2020, 16'h2020, 1'b0, 16'h0000, 16'h0000, "t2 pair2 d");
`else
      do_fill(1'b1, 16'h2020, 16'h2020, 1'b1, 16'h3010, 16'h0000, "t2 pair2 d");
      do_fill(1'b0, 16'h3010, 16'h3010, 1'b0, 16'h0000, 16'h0000, "t2 pair2 i");
`endif

      // ---- memory stalls with 0..3 cycle gaps between returned words ----
      do_fill(1'b0, 16'hABCD, 16'hABCD, 1'b0, 16'h0000, 16'hE4E4, "t3 gaps");
      vi = '0; ve = '0;
      apply(vi, ve, "t3 idle");

      // ---- reset after three words of a D fill ----
      vi = '0; vi.dc_miss = 1'b1; vi.dc_addr = 16'h5557;
      ve = '0; ve.dc_busy = 1'b1;
      apply(vi, ve, "t4 grant");
      for (int t = 0; t < 5; t++) begin
         vi.mem_dv   = (t >= 2);
         ve          = '0;
         ve.dc_busy  = 1'b1;
         ve.mem_en   = 1'b1;
         ve.mem_addr = 16'h5550 + 16'(2 * t);
         ve.dc_dv    = vi.mem_dv;
         ve.dc_off   = (t >= 2) ? 3'(t - 2) : 3'd0;
         apply(vi, ve, $sformatf("t4 t%0d", t));
      end
      vi = '0; vi.rst = 1'b1;
      ve = '0; ve.dc_busy = 1'b1; ve.dc_off = 3'd3; ve.mem_en = 1'b1; ve.mem_addr = 16'h555A;
      apply(vi, ve, "t4 rst");
      vi.mem_dv = 1'b1; ve = '0;
      apply(vi, ve, "t4 after rst");
      vi.rst = 1'b0;
      apply(vi, ve, "t4 residual0");
      apply(vi, ve, "t4 residual1");

      // ---- address change mid-fill is ignored ----
      do_fill(1'b1, 16'h0040, 16'hFFF0, 1'b0, 16'h0000, 16'h1B60, "t5 addr");
      vi = '0; ve = '0;
      apply(vi, ve, "t5 idle");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
